// File: rtl/ctrl_types_pkg.sv
// ctrl_types_pkg: shared cache-controller types (opcodes, status, front-end FSM state and command record)
package ctrl_types_pkg;
  localparam int FE_KEY_W = 16;
  localparam int FE_VAL_W = 32;
  typedef enum logic [2:0] {
    OP_NOOP   = 3'b000,
    OP_READ   = 3'b001,
    OP_UPSERT = 3'b010,
    OP_DELETE = 3'b011
  } operation_e;
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;
  typedef enum logic [1:0] {FE_IDLE, FE_ISSUE, FE_WAIT, FE_RESP} fe_state_e;
  typedef struct packed {
    operation_e            op;
    logic [FE_KEY_W-1:0]   key;
    logic [FE_VAL_W-1:0]   val;
  } fe_cmd_t;
  // Opcodes 3'b100..3'b111 are unassigned and rejected by the front end.
  function automatic logic is_legal_op(input logic [2:0] op);
    return !op[2];
  endfunction
endpackage

// File: rtl/ctrl_cmd_fifo.sv
// ctrl_cmd_fifo: synchronous FIFO; ports clk, rst_n, push/wdata, pop/rdata, full, empty
module ctrl_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/ctrl_cmd_frontend.sv
// ctrl_cmd_frontend: buffers host commands and issues them one at a time to the cache controller
// Ports: req_* host command in (valid/ready), ctl_* controller issue/abort out and status/rdata in,
// rsp_* per-command response out (valid/ready). clk, rst_n (async active-low).
module ctrl_cmd_frontend
  import ctrl_types_pkg::*;
#(
  parameter int KEY_W   = FE_KEY_W,
  parameter int VAL_W   = FE_VAL_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [KEY_W-1:0] req_key_i,
  input  logic [VAL_W-1:0] req_val_i,
  output logic             ctl_start_o,
  output logic [2:0]       ctl_op_o,
  output logic [KEY_W-1:0] ctl_key_o,
  output logic [VAL_W-1:0] ctl_val_o,
  output logic             ctl_abort_o,
  input  logic [1:0]       ctl_status_i,
  input  logic [VAL_W-1:0] ctl_rdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [2:0]       rsp_op_o,
  output logic             rsp_error_o,
  output logic             rsp_timeout_o,
  output logic [VAL_W-1:0] rsp_data_o
);
  localparam int TW = $clog2(TIMEOUT);
  fe_state_e state, state_n;
  fe_cmd_t wr_cmd, rd_cmd, cmd_q;
  sub_cmd_t status;
  logic full, empty, push, pop, hit, expire;
  logic [TW-1:0] timer;
  assign status = sub_cmd_t'(ctl_status_i);
  assign req_ready_o = !full;
  // NOOPs complete the handshake but are never queued.
  assign push = req_valid_i && !full && req_op_i != OP_NOOP;
  assign wr_cmd = '{op: operation_e'(req_op_i), key: req_key_i, val: req_val_i};
  assign pop = state == FE_IDLE && !empty;
  assign hit = state == FE_WAIT && (status.done || status.error);
  // Status arriving in the last allowed cycle beats the timeout.
  assign expire = state == FE_WAIT && !hit && timer == TW'(TIMEOUT - 1);
  ctrl_cmd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fe_cmd_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (rd_cmd),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FE_IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = pop ? (is_legal_op(rd_cmd.op) ? FE_ISSUE : FE_RESP) :
              state == FE_ISSUE ? FE_WAIT :
              (hit || expire) ? FE_RESP :
              (state == FE_RESP && rsp_ready_i) ? FE_IDLE : state;
  end
  always_comb begin
    ctl_start_o = state == FE_ISSUE;
    ctl_abort_o = expire;
    rsp_valid_o = state == FE_RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_q         <= '0;
      timer         <= '0;
      rsp_error_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_data_o    <= '0;
    end else begin
      timer <= state == FE_ISSUE ? '0 : state == FE_WAIT ? timer + 1'b1 : timer;
      if (pop) begin
        cmd_q         <= rd_cmd;
        rsp_error_o   <= !is_legal_op(rd_cmd.op);
        rsp_timeout_o <= 1'b0;
        rsp_data_o    <= '0;
      end else if (hit) begin
        rsp_error_o <= status.error;
        rsp_data_o  <= (cmd_q.op == OP_READ && !status.error) ? ctl_rdata_i : '0;
      end else if (expire) begin
        rsp_error_o   <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end
    end
  assign ctl_op_o  = cmd_q.op;
  assign ctl_key_o = cmd_q.key;
  assign ctl_val_o = cmd_q.val;
  assign rsp_op_o  = cmd_q.op;
endmodule
